// File: rtl/traffic_light_pkg.sv
// Shared definitions for the junction controller: state codes, lamp codes,
// default phase durations and the per-state dwell-time lookup.
package traffic_light_pkg;

  localparam logic [2:0] S1 = 3'd0;
  localparam logic [2:0] S2 = 3'd1;
  localparam logic [2:0] S3 = 3'd2;
  localparam logic [2:0] S4 = 3'd3;
  localparam logic [2:0] S5 = 3'd4;
  localparam logic [2:0] S6 = 3'd5;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam int unsigned T_S1_DEF = 7;
  localparam int unsigned T_S2_DEF = 2;
  localparam int unsigned T_S3_DEF = 5;
  localparam int unsigned T_S4_DEF = 2;
  localparam int unsigned T_S5_DEF = 3;
  localparam int unsigned T_S6_DEF = 2;

  // Illegal states report a dwell of one so they never hold the counter.
  function automatic logic [3:0] dwell_time(
    input logic [2:0] state,
    input logic [3:0] t1,
    input logic [3:0] t2,
    input logic [3:0] t3,
    input logic [3:0] t4,
    input logic [3:0] t5,
    input logic [3:0] t6
  );
    case (state)
      S1:      dwell_time = t1;
      S2:      dwell_time = t2;
      S3:      dwell_time = t3;
      S4:      dwell_time = t4;
      S5:      dwell_time = t5;
      S6:      dwell_time = t6;
      default: dwell_time = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light.sv
// Six-phase Moore controller for a four-signal junction (M1, M2, MT, ST),
// stepping once per 1 Hz clock with a fixed dwell count per phase.
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int unsigned T_S1 = T_S1_DEF,
  parameter int unsigned T_S2 = T_S2_DEF,
  parameter int unsigned T_S3 = T_S3_DEF,
  parameter int unsigned T_S4 = T_S4_DEF,
  parameter int unsigned T_S5 = T_S5_DEF,
  parameter int unsigned T_S6 = T_S6_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_ST
);

  localparam logic [3:0] T1 = T_S1[3:0];
  localparam logic [3:0] T2 = T_S2[3:0];
  localparam logic [3:0] T3 = T_S3[3:0];
  localparam logic [3:0] T4 = T_S4[3:0];
  localparam logic [3:0] T5 = T_S5[3:0];
  localparam logic [3:0] T6 = T_S6[3:0];

  // Register names ps/count are observed hierarchically by benches.
  logic [2:0] ps;
  logic [3:0] count;
  logic [2:0] ps_d;
  logic [3:0] count_d;
  logic [3:0] t_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps    <= S1;
      count <= 4'd0;
    end else begin
      ps    <= ps_d;
      count <= count_d;
    end
  end

  // >= rather than == so a corrupted count still ends the phase.
  always_comb begin
    t_cur   = dwell_time(ps, T1, T2, T3, T4, T5, T6);
    ps_d    = ps;
    count_d = count + 4'd1;
    if (ps > S6) begin
      ps_d    = S1;
      count_d = 4'd0;
    end else if (count >= (t_cur - 4'd1)) begin
      count_d = 4'd0;
      case (ps)
        S1:      ps_d = S2;
        S2:      ps_d = S3;
        S3:      ps_d = S4;
        S4:      ps_d = S5;
        S5:      ps_d = S6;
        S6:      ps_d = S1;
        default: ps_d = S1;
      endcase
    end else begin
      ps_d    = ps;
      count_d = count + 4'd1;
    end
  end

  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_ST = RED;
    case (ps)
      S1: begin
        light_M1 = GREEN;
        light_M2 = GREEN;
      end
      S2: begin
        light_M1 = GREEN;
        light_M2 = YELLOW;
      end
      S3: begin
        light_M1 = GREEN;
        light_MT = GREEN;
      end
      S4: begin
        light_M1 = YELLOW;
        light_MT = YELLOW;
      end
      S5:      light_ST = GREEN;
      S6:      light_ST = YELLOW;
      default: light_ST = RED;
    endcase
  end

endmodule

// File: tb/tb_traffic_light.sv
// Scoreboard bench for traffic_light: an independent phase model pushes the
// expected state/count/lamps per clock, popped and compared after each edge.
`timescale 1ns/1ps
module tb_traffic_light;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  typedef struct packed {
    logic [2:0]  ps;
    logic [3:0]  cnt;
    logic [11:0] lamps;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] light_M1, light_M2, light_MT, light_ST;

  int checks = 0;
  int errors = 0;
  int m_ps = 0;
  int m_cnt = 0;
  int dur [6] = '{7, 2, 5, 2, 3, 2};
  exp_t sb [$];

  traffic_light dut (
    .clk      (clk),
    .rst      (rst),
    .light_M1 (light_M1),
    .light_M2 (light_M2),
    .light_MT (light_MT),
    .light_ST (light_ST)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_lamps(input int s);
    case (s)
      0:       exp_lamps = {G, G, R, R};
      1:       exp_lamps = {G, Y, R, R};
      2:       exp_lamps = {G, R, G, R};
      3:       exp_lamps = {Y, R, Y, R};
      4:       exp_lamps = {R, R, R, G};
      5:       exp_lamps = {R, R, R, Y};
      default: exp_lamps = {R, R, R, R};
    endcase
  endfunction

  // Advance the model one clock, push its prediction, clock the DUT, pop and compare.
  task automatic tick(input string name);
    exp_t e;
    logic [11:0] got;
    if (m_cnt == dur[m_ps] - 1) begin
      m_ps  = (m_ps + 1) % 6;
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
    e.ps = m_ps[2:0];
    e.cnt = m_cnt[3:0];
    e.lamps = exp_lamps(m_ps);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    got = {light_M1, light_M2, light_MT, light_ST};
    checks++;
    if (dut.ps !== e.ps || dut.count !== e.cnt || got !== e.lamps) begin
      errors++;
      $display("FAIL %s: got ps=%0d count=%0d lamps=%b, expected ps=%0d count=%0d lamps=%b",
               name, dut.ps, dut.count, got, e.ps, e.cnt, e.lamps);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ps = 0;
    m_cnt = 0;
    checks++;
    if (dut.ps !== 3'd0 || dut.count !== 4'd0 ||
        {light_M1, light_M2, light_MT, light_ST} !== {G, G, R, R}) begin
      errors++;
      $display("FAIL reset: got ps=%0d count=%0d lamps=%b%b%b%b, expected ps=0 count=0 lamps=001001100100",
               dut.ps, dut.count, light_M1, light_M2, light_MT, light_ST);
    end
  endtask

  task automatic test_free_run();
    int lens [$];
    int cur;
    int len;
    cur = int'(dut.ps);
    len = 1;
    for (int i = 0; i < 21; i++) begin
      tick("free_run");
      if (int'(dut.ps) == cur) begin
        len++;
      end else begin
        lens.push_back(len);
        cur = int'(dut.ps);
        len = 1;
      end
    end
    checks++;
    if (lens.size() != 6) begin
      errors++;
      $display("FAIL dwell_count: got %0d phases, expected 6", lens.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (lens[k] != dur[k]) begin
          errors++;
          $display("FAIL dwell_S%0d: got %0d cycles, expected %0d", k + 1, lens[k], dur[k]);
        end
      end
    end
  endtask

  task automatic test_count_ramp();
    logic [2:0] prev_ps;
    logic [3:0] prev_cnt;
    logic [3:0] want;
    for (int i = 0; i < 21; i++) begin
      prev_ps = dut.ps;
      prev_cnt = dut.count;
      tick("count_ramp_sb");
      want = (dut.ps != prev_ps) ? 4'd0 : prev_cnt + 4'd1;
      checks++;
      if (dut.count !== want) begin
        errors++;
        $display("FAIL count_ramp: got count=%0d, expected %0d", dut.count, want);
      end
    end
  endtask

  task automatic test_async_reset_mid_s3();
    int s1_len;
    int guard;
    guard = 0;
    while (!(m_ps == 2 && m_cnt == 2) && guard < 40) begin
      tick("pre_mid_s3");
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL reach_s3: got no S3 count=2 within 40 cycles, expected it");
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut.ps !== 3'd0 || dut.count !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: got ps=%0d count=%0d, expected ps=0 count=0", dut.ps, dut.count);
    end
    #1 rst = 1'b0;
    m_ps = 0;
    m_cnt = 0;
    s1_len = 1;
    for (int i = 0; i < 8; i++) begin
      tick("post_reset");
      if (dut.ps == 3'd0) s1_len++;
    end
    checks++;
    if (s1_len != 7) begin
      errors++;
      $display("FAIL s1_after_reset: got %0d cycles, expected 7", s1_len);
    end
  endtask

  task automatic test_illegal_state();
    tick("pre_illegal");
    tick("pre_illegal");
    force dut.ps = 3'd6;
    #1;
    checks++;
    if ({light_M1, light_M2, light_MT, light_ST} !== {R, R, R, R}) begin
      errors++;
      $display("FAIL illegal_lamps: got %b%b%b%b, expected 100100100100",
               light_M1, light_M2, light_MT, light_ST);
    end
    release dut.ps;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut.ps !== 3'd0 || dut.count !== 4'd0) begin
      errors++;
      $display("FAIL illegal_recover: got ps=%0d count=%0d, expected ps=0 count=0", dut.ps, dut.count);
    end
    m_ps = 0;
    m_cnt = 0;
  endtask

  task automatic test_safety_run();
    logic [2:0] lamp [4];
    for (int i = 0; i < 200; i++) begin
      tick("safety_sb");
      lamp[0] = light_M1;
      lamp[1] = light_M2;
      lamp[2] = light_MT;
      lamp[3] = light_ST;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (!(lamp[k] == R || lamp[k] == Y || lamp[k] == G)) begin
          errors++;
          $display("FAIL onehot_lamp%0d: got %b, expected one of 100/010/001", k, lamp[k]);
        end
      end
      checks++;
      if (light_MT != R && light_M2 != R) begin
        errors++;
        $display("FAIL mt_vs_m2: got MT=%b M2=%b, expected one of them red", light_MT, light_M2);
      end
      checks++;
      if (light_ST != R && (light_M1 != R || light_M2 != R || light_MT != R)) begin
        errors++;
        $display("FAIL st_vs_main: got ST=%b M1=%b M2=%b MT=%b, expected others red",
                 light_ST, light_M1, light_M2, light_MT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_count_ramp();
    test_async_reset_mid_s3();
    test_illegal_state();
    test_safety_run();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
